// File: rtl/riscv_cbm_sched.sv
// rtl/riscv_cbm_sched.sv - shares the single CBM unit between issue pipes A and B.
// Optional launch-to-done watchdog enabled by defining CBM_SCHED_TIMEOUT_EN.
module riscv_cbm_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_a_valid_i,
  input  logic [31:0] req_a_ra_i,
  input  logic [31:0] req_a_rb_i,
  input  logic [4:0]  req_a_rd_i,
  input  logic        req_b_valid_i,
  input  logic [31:0] req_b_ra_i,
  input  logic [31:0] req_b_rb_i,
  input  logic [4:0]  req_b_rd_i,
  output logic        req_a_accept_o,
  output logic        req_b_accept_o,
  input  logic        flush_i,
  output logic        cbm_valid_o,
  output logic [31:0] cbm_ra_o,
  output logic [31:0] cbm_rb_o,
  output logic [4:0]  cbm_rd_o,
  input  logic        cbm_busy_i,
  input  logic        cbm_done_i,
  input  logic [31:0] cbm_result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_value_o,
  input  logic        wb_ready_i,
  output logic        pending_valid_o,
  output logic [4:0]  pending_rd_o,
  output logic        busy_o,
  output logic        error_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] ra_q, ra_d;
  logic [31:0] rb_q, rb_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        squash_q, squash_d;
  logic        idle_ok;
  logic        wd_expire;
  logic        unused_busy;

  // The CBM's own busy flag is redundant: only one op is ever outstanding.
  assign unused_busy = cbm_busy_i;

  // Pipe A is older, so it always wins; reset and flush block any accept.
  assign idle_ok        = (state_q == ST_IDLE) && !flush_i && !rst_i;
  assign req_a_accept_o = idle_ok && req_a_valid_i;
  assign req_b_accept_o = idle_ok && !req_a_valid_i && req_b_valid_i;

`ifdef CBM_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             error_q, error_d;

  assign wd_expire = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = '0;
    error_d  = 1'b0;
    if (state_q == ST_WAIT) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
      error_d  = wd_expire && !cbm_done_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error_o = error_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign wd_expire = 1'b0;
  assign error_o   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    result_d = result_q;
    squash_d = squash_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a_accept_o) begin
          ra_d    = req_a_ra_i;
          rb_d    = req_a_rb_i;
          rd_d    = req_a_rd_i;
          state_d = ST_LAUNCH;
        end else if (req_b_accept_o) begin
          ra_d    = req_b_ra_i;
          rb_d    = req_b_rb_i;
          rd_d    = req_b_rd_i;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        if (flush_i) begin
          squash_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Done beats the watchdog when both land in the same cycle.
        if (cbm_done_i) begin
          result_d = cbm_result_i;
          if (squash_q || flush_i || (rd_q == 5'd0)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end else if (flush_i) begin
          squash_d = 1'b1;
        end
      end
      ST_WB: begin
        if (flush_i || wb_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_IDLE) begin
      squash_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      squash_q <= squash_d;
    end
  end

  assign cbm_valid_o     = (state_q == ST_LAUNCH);
  assign cbm_ra_o        = ra_q;
  assign cbm_rb_o        = rb_q;
  assign cbm_rd_o        = rd_q;
  assign wb_valid_o      = (state_q == ST_WB);
  assign wb_rd_o         = rd_q;
  assign wb_value_o      = result_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign pending_valid_o = busy_o && !squash_q && (rd_q != 5'd0);
  assign pending_rd_o    = rd_q;

endmodule

// File: tb/tb_riscv_cbm_sched.sv
// tb/tb_riscv_cbm_sched.sv - directed bench for riscv_cbm_sched with a fixed-latency CBM stand-in.
module tb_riscv_cbm_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic [31:0] req_a_ra = '0, req_a_rb = '0, req_b_ra = '0, req_b_rb = '0;
  logic [4:0]  req_a_rd = '0, req_b_rd = '0;
  logic        req_a_accept_o, req_b_accept_o;
  logic        flush = 1'b0;
  logic        cbm_valid_o;
  logic [31:0] cbm_ra_o, cbm_rb_o;
  logic [4:0]  cbm_rd_o;
  logic        cbm_busy_i = 1'b0, cbm_done_i = 1'b0;
  logic [31:0] cbm_result_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        wb_ready = 1'b0;
  logic        pending_valid_o;
  logic [4:0]  pending_rd_o;
  logic        busy_o, error_o;

  int checks = 0;
  int failures = 0;

  logic        model_en = 1'b1;
  int          model_cnt = 0;
  logic [31:0] model_prod = '0;

  always #5 clk = ~clk;

  riscv_cbm_sched #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_valid_i(req_a_valid), .req_a_ra_i(req_a_ra), .req_a_rb_i(req_a_rb), .req_a_rd_i(req_a_rd),
    .req_b_valid_i(req_b_valid), .req_b_ra_i(req_b_ra), .req_b_rb_i(req_b_rb), .req_b_rd_i(req_b_rd),
    .req_a_accept_o(req_a_accept_o), .req_b_accept_o(req_b_accept_o),
    .flush_i(flush),
    .cbm_valid_o(cbm_valid_o), .cbm_ra_o(cbm_ra_o), .cbm_rb_o(cbm_rb_o), .cbm_rd_o(cbm_rd_o),
    .cbm_busy_i(cbm_busy_i), .cbm_done_i(cbm_done_i), .cbm_result_i(cbm_result_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_value_o(wb_value_o), .wb_ready_i(wb_ready),
    .pending_valid_o(pending_valid_o), .pending_rd_o(pending_rd_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  // CBM stand-in: done pulses two cycles after the launch cycle, low 32 bits of the product.
  always @(negedge clk) begin
    cbm_done_i = 1'b0;
    if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) begin
        cbm_done_i   = 1'b1;
        cbm_result_i = model_prod;
      end
    end
    if (model_en && cbm_valid_o) begin
      model_cnt  = 2;
      model_prod = cbm_ra_o * cbm_rb_o;
    end
    cbm_busy_i = (model_cnt > 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    req_a_ra = '0; req_a_rb = '0; req_a_rd = '0;
    req_b_ra = '0; req_b_rb = '0; req_b_rd = '0;
    flush = 1'b0; wb_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_en = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd1; req_a_rb = 32'd1; req_a_rd = 5'd1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_a_accept_o, req_b_accept_o, cbm_valid_o, cbm_ra_o, cbm_rb_o, cbm_rd_o, wb_valid_o, wb_rd_o,
         wb_value_o, pending_valid_o, pending_rd_o, busy_o, error_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs accept_a=%b cbm_valid=%b busy=%b", req_a_accept_o, cbm_valid_o, busy_o);
    end
    do_reset();
  endtask

  task automatic test_single_a();
    @(negedge clk);
    wb_ready = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd7; req_a_rb = 32'd6; req_a_rd = 5'd13;
    #1;
    checks++;
    if ({req_a_accept_o, req_b_accept_o} !== 2'b10) begin
      failures++; $display("FAIL single_accept: got %b expected 10", {req_a_accept_o, req_b_accept_o});
    end
    @(negedge clk);
    req_a_valid = 1'b0;
    #1;
    checks++;
    if ({cbm_valid_o, cbm_ra_o, cbm_rb_o, cbm_rd_o} !== {1'b1, 32'd7, 32'd6, 5'd13}) begin
      failures++; $display("FAIL single_launch: got valid=%b ra=%0d rb=%0d rd=%0d expected 1 7 6 13", cbm_valid_o, cbm_ra_o, cbm_rb_o, cbm_rd_o);
    end
    checks++;
    if ({pending_valid_o, pending_rd_o, busy_o} !== {1'b1, 5'd13, 1'b1}) begin
      failures++; $display("FAIL single_pending: got pv=%b prd=%0d busy=%b expected 1 13 1", pending_valid_o, pending_rd_o, busy_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cbm_valid_o, busy_o} !== 2'b01) begin
      failures++; $display("FAIL single_launch_pulse: got valid=%b busy=%b expected 0 1", cbm_valid_o, busy_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_valid_o !== 1'b0) begin
      failures++; $display("FAIL single_wb_early: got %b expected 0", wb_valid_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_value_o, pending_valid_o, pending_rd_o} !== {1'b1, 5'd13, 32'd42, 1'b1, 5'd13}) begin
      failures++; $display("FAIL single_wb: got v=%b rd=%0d val=%0d pv=%b prd=%0d expected 1 13 42 1 13", wb_valid_o, wb_rd_o, wb_value_o, pending_valid_o, pending_rd_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy_o, pending_valid_o, wb_valid_o} !== 3'b000) begin
      failures++; $display("FAIL single_idle: got busy=%b pv=%b wbv=%b expected 000", busy_o, pending_valid_o, wb_valid_o);
    end
  endtask

  task automatic test_both_valid();
    int b_acc = -1;
    int nwb = 0;
    bit drop = 0;
    logic [31:0] wv [2];
    logic [4:0]  wr [2];
    int          wc [2];
    @(negedge clk);
    wb_ready = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd3; req_a_rb = 32'd5; req_a_rd = 5'd10;
    req_b_valid = 1'b1; req_b_ra = 32'd9; req_b_rb = 32'd9; req_b_rd = 5'd11;
    #1;
    checks++;
    if ({req_a_accept_o, req_b_accept_o} !== 2'b10) begin
      failures++; $display("FAIL both_priority: got %b expected 10", {req_a_accept_o, req_b_accept_o});
    end
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) req_a_valid = 1'b0;
      if (drop) req_b_valid = 1'b0;
      drop = 0;
      #1;
      if (wb_valid_o && wb_ready) begin
        if (nwb < 2) begin
          wv[nwb] = wb_value_o; wr[nwb] = wb_rd_o; wc[nwb] = i;
        end
        nwb++;
      end
      if (req_b_accept_o) begin
        b_acc = i;
        drop = 1;
      end
    end
    checks++;
    if (b_acc != 5) begin
      failures++; $display("FAIL both_b_accept_cycle: got %0d expected 5", b_acc);
    end
    checks++;
    if (nwb != 2) begin
      failures++; $display("FAIL both_wb_count: got %0d expected 2", nwb);
    end else begin
      checks++;
      if ({wv[0], wr[0], wv[1], wr[1]} !== {32'd15, 5'd10, 32'd81, 5'd11}) begin
        failures++; $display("FAIL both_wb_order: got %0d/%0d then %0d/%0d expected 15/10 then 81/11", wv[0], wr[0], wv[1], wr[1]);
      end
      checks++;
      if (wc[0] != 4 || wc[1] != 9) begin
        failures++; $display("FAIL both_wb_cycles: got %0d,%0d expected 4,9", wc[0], wc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int first_wb = -1;
    int nvalid = 0;
    int bad = 0;
    int hs = 0;
    logic busy10 = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    req_a_valid = 1'b1; req_a_ra = 32'hFFFF_FFFF; req_a_rb = 32'd2; req_a_rd = 5'd5;
    #1;
    checks++;
    if (req_a_accept_o !== 1'b1) begin
      failures++; $display("FAIL bp_accept: got %b expected 1", req_a_accept_o);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) req_a_valid = 1'b0;
      wb_ready = (i >= 9);
      #1;
      if (wb_valid_o) begin
        nvalid++;
        if (first_wb < 0) first_wb = i;
        if ({wb_rd_o, wb_value_o} !== {5'd5, 32'hFFFF_FFFE}) bad++;
        if (wb_ready) hs++;
      end
      if (i == 10) busy10 = busy_o;
    end
    wb_ready = 1'b0;
    checks++;
    if (first_wb != 4 || nvalid != 6) begin
      failures++; $display("FAIL bp_valid_window: got first=%0d cycles=%0d expected 4 6", first_wb, nvalid);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
    end
    checks++;
    if (hs != 1 || busy10 !== 1'b0) begin
      failures++; $display("FAIL bp_handshake: got hs=%0d busy_after=%b expected 1 0", hs, busy10);
    end
  endtask

  task automatic test_rd_zero();
    logic pend_seen = 1'b0;
    logic wb_seen = 1'b0;
    logic busy3 = 1'b0, busy4 = 1'b1;
    @(negedge clk);
    wb_ready = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd4; req_a_rb = 32'd4; req_a_rd = 5'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) req_a_valid = 1'b0;
      #1;
      pend_seen = pend_seen | pending_valid_o;
      wb_seen = wb_seen | wb_valid_o;
      if (i == 3) busy3 = busy_o;
      if (i == 4) busy4 = busy_o;
    end
    checks++;
    if ({pend_seen, wb_seen} !== 2'b00) begin
      failures++; $display("FAIL rd0_no_wb: got pending=%b wb=%b expected 0 0", pend_seen, wb_seen);
    end
    checks++;
    if ({busy3, busy4} !== 2'b10) begin
      failures++; $display("FAIL rd0_idle_after_done: got busy3=%b busy4=%b expected 1 0", busy3, busy4);
    end
  endtask

  task automatic test_flush_wait();
    logic p2 = 1'b0, p3 = 1'b1;
    int b_acc = -1;
    int nwb = 0;
    int wbc = -1;
    logic [4:0] wbrd = '0;
    logic [31:0] wbval = '0;
    bit drop = 0;
    @(negedge clk);
    wb_ready = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd2; req_a_rb = 32'd3; req_a_rd = 5'd7;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) req_a_valid = 1'b0;
      flush = (i == 2);
      if (i == 3) begin
        req_b_valid = 1'b1; req_b_ra = 32'd5; req_b_rb = 32'd5; req_b_rd = 5'd9;
      end
      if (drop) req_b_valid = 1'b0;
      drop = 0;
      #1;
      if (i == 2) p2 = pending_valid_o;
      if (i == 3) p3 = pending_valid_o;
      if (req_b_accept_o) begin
        b_acc = i;
        drop = 1;
      end
      if (wb_valid_o && wb_ready) begin
        nwb++; wbrd = wb_rd_o; wbval = wb_value_o; wbc = i;
      end
    end
    checks++;
    if ({p2, p3} !== 2'b10) begin
      failures++; $display("FAIL flush_pending: got before=%b after=%b expected 1 0", p2, p3);
    end
    checks++;
    if (b_acc != 4) begin
      failures++; $display("FAIL flush_next_accept: got cycle %0d expected 4", b_acc);
    end
    checks++;
    if (nwb != 1 || wbrd !== 5'd9 || wbval !== 32'd25 || wbc != 8) begin
      failures++; $display("FAIL flush_wb: got n=%0d rd=%0d val=%0d cyc=%0d expected 1 9 25 8", nwb, wbrd, wbval, wbc);
    end
  endtask

  task automatic test_flush_idle_wb();
    int nv = 0;
    logic busy6 = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    req_a_valid = 1'b1; req_a_ra = 32'd3; req_a_rb = 32'd3; req_a_rd = 5'd4;
    flush = 1'b1;
    #1;
    checks++;
    if (req_a_accept_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle_block: got %b expected 0", req_a_accept_o);
    end
    flush = 1'b0;
    #1;
    checks++;
    if (req_a_accept_o !== 1'b1) begin
      failures++; $display("FAIL flush_idle_release: got %b expected 1", req_a_accept_o);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) req_a_valid = 1'b0;
      flush = (i == 5);
      #1;
      if (wb_valid_o) nv++;
      if (i == 6) busy6 = busy_o;
    end
    flush = 1'b0;
    checks++;
    if (nv != 2 || busy6 !== 1'b0) begin
      failures++; $display("FAIL flush_wb_drop: got wb_cycles=%0d busy=%b expected 2 0", nv, busy6);
    end
  endtask

  task automatic test_reset_mid_op();
    logic wb_seen = 1'b0;
    logic busy_seen = 1'b0;
    @(negedge clk);
    wb_ready = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd6; req_a_rb = 32'd7; req_a_rd = 5'd3;
    @(negedge clk);
    req_a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({req_a_accept_o, req_b_accept_o, cbm_valid_o, cbm_ra_o, cbm_rb_o, cbm_rd_o, wb_valid_o, wb_rd_o,
         wb_value_o, pending_valid_o, pending_rd_o, busy_o, error_o} !== '0) begin
      failures++; $display("FAIL reset_mid_op: got busy=%b pv=%b prd=%0d cbm_ra=%0d expected all 0", busy_o, pending_valid_o, pending_rd_o, cbm_ra_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      wb_seen = wb_seen | wb_valid_o;
      busy_seen = busy_seen | busy_o;
    end
    checks++;
    if ({wb_seen, busy_seen} !== 2'b00) begin
      failures++; $display("FAIL reset_abandon: got wb=%b busy=%b expected 0 0", wb_seen, busy_seen);
    end
  endtask

`ifdef CBM_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int nerr = 0;
    int errc = -1;
    logic busy10 = 1'b1;
    logic pend9 = 1'b0;
    @(negedge clk);
    model_en = 1'b0;
    wb_ready = 1'b1;
    req_a_valid = 1'b1; req_a_ra = 32'd1; req_a_rb = 32'd1; req_a_rd = 5'd2;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) req_a_valid = 1'b0;
      #1;
      if (error_o) begin
        nerr++; errc = i;
      end
      if (i == 9) pend9 = pending_valid_o;
      if (i == 10) busy10 = busy_o;
    end
    model_en = 1'b1;
    checks++;
    if (nerr != 1 || errc != 10) begin
      failures++; $display("FAIL timeout_pulse: got count=%0d cycle=%0d expected 1 10", nerr, errc);
    end
    checks++;
    if ({pend9, busy10} !== 2'b10) begin
      failures++; $display("FAIL timeout_idle: got pend_before=%b busy_after=%b expected 1 0", pend9, busy10);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_both_valid();
    clear_inputs();
    test_backpressure();
    clear_inputs();
    test_rd_zero();
    clear_inputs();
    test_flush_wait();
    clear_inputs();
    test_flush_idle_wb();
    clear_inputs();
    test_reset_mid_op();
    clear_inputs();
`ifdef CBM_SCHED_TIMEOUT_EN
    test_timeout();
    clear_inputs();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
